data_memory_ws: RTL and testbench

//  Parametrised word-addressed data memory for the MEM stage, with byte-lane writes, a programmable

---
 rtl/data_memory_ws_if.sv | 28 ++
 rtl/data_memory_ws.sv | 161 ++++++++++++++++
 tb/tb_data_memory_ws.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ws_if.sv
// Request/ready bus between the MEM stage and the wait-state data memory.
// master: drives rd_en, wr_en, addr, wdata, wstrb; samples rdata, ready, err, stall.
// slave : the memory; drives rdata, ready, err, stall.
interface data_memory_ws_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              rd_en;
   logic              wr_en;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              err;
   logic              stall;

   modport master (
      output rd_en, wr_en, addr, wdata, wstrb,
      input  rdata, ready, err, stall
   );

   modport slave (
      input  rd_en, wr_en, addr, wdata, wstrb,
      output rdata, ready, err, stall
   );
endinterface

// File: rtl/data_memory_ws.sv
// Word-addressed data memory for the MEM stage with byte-lane writes,
// a fixed wait-state count, a request/ready handshake and a range check.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of data_memory_ws_if:
//          rd_en/wr_en/addr/wdata/wstrb in; rdata/ready/err registered out;
//          stall combinational out = (rd_en|wr_en) & ~ready
module data_memory_ws #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned WORDS        = 64,
   parameter int unsigned BASE_ADDR    = 1024,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   data_memory_ws_if.slave  bus
);
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] BASE     = 32'(BASE_ADDR);
   localparam logic [31:0] SPAN     = 32'(WORDS * 4);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [DATA_W-1:0] mem [WORDS];

   state_t            state;
   logic [3:0]        cnt;
   logic [IDX_W-1:0]  idx_q;
   logic              in_range_q;
   logic              is_wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ready_q;
   logic              err_q;

   // Address decode on the live request
   logic [31:0]       off_c;
   logic [IDX_W-1:0]  idx_c;
   logic              in_range_c;
   logic              req_c;

   assign off_c      = bus.addr - BASE;
   assign idx_c      = off_c[2 +: IDX_W];
   assign in_range_c = (bus.addr >= BASE) && (off_c < SPAN);
   assign req_c      = bus.rd_en | bus.wr_en;

   // Commit happens on the edge entering RESP; with no wait states that edge
   // is the accepting one, so the live request is used instead of the capture.
   logic              commit_c;
   logic              c_wr;
   logic              c_ok;
   logic [IDX_W-1:0]  c_idx;
   logic [DATA_W-1:0] c_wdata;
   logic [STRB_W-1:0] c_wstrb;

   always_comb begin
      commit_c = 1'b0;
      c_wr     = is_wr_q;
      c_ok     = in_range_q;
      c_idx    = idx_q;
      c_wdata  = wdata_q;
      c_wstrb  = wstrb_q;
      case (state)
         S_IDLE: begin
            if (req_c && NO_WAIT) begin
               commit_c = 1'b1;
               c_wr     = bus.wr_en;
               c_ok     = in_range_c;
               c_idx    = idx_c;
               c_wdata  = bus.wdata;
               c_wstrb  = bus.wstrb;
            end
         end
         S_WAIT:  commit_c = (cnt == 4'd0);
         default: commit_c = 1'b0;
      endcase
   end

   // Storage array with per-lane write enables
   always_ff @(posedge clk) begin
      if (rst) begin
         if (CLEAR_ON_RST) begin
            for (int w = 0; w < int'(WORDS); w++) begin
               mem[w] <= '0;
            end
         end
      end else if (commit_c && c_wr && c_ok) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (c_wstrb[i]) begin
               mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
         end
      end
   end

   // Access sequencer and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         is_wr_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (commit_c) begin
            ready_q <= 1'b1;
            err_q   <= ~c_ok;
            if (!c_ok) begin
               rdata_q <= '0;
            end else if (!c_wr) begin
               rdata_q <= mem[c_idx];
            end
         end

         case (state)
            S_IDLE: begin
               if (req_c) begin
                  is_wr_q    <= bus.wr_en;
                  idx_q      <= idx_c;
                  in_range_q <= in_range_c;
                  wdata_q    <= bus.wdata;
                  wstrb_q    <= bus.wstrb;
                  if (NO_WAIT) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.stall = req_c & ~ready_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench for data_memory_ws: two instances driven in lockstep, one
// clearing memory on reset and one preserving it.
module tb_data_memory_ws;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        chk;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_memory_ws_if #(.DATA_W(DATA_W)) b1 ();
   data_memory_ws_if #(.DATA_W(DATA_W)) b2 ();

   assign b2.rd_en = b1.rd_en;
   assign b2.wr_en = b1.wr_en;
   assign b2.addr  = b1.addr;
   assign b2.wdata = b1.wdata;
   assign b2.wstrb = b1.wstrb;

   data_memory_ws #(
      .DATA_W(DATA_W), .WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(2), .CLEAR_ON_RST(1'b1)
   ) dut_clr (
      .clk(clk), .rst(rst), .bus(b1)
   );

   data_memory_ws #(
      .DATA_W(DATA_W), .WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(2), .CLEAR_ON_RST(1'b0)
   ) dut_keep (
      .clk(clk), .rst(rst), .bus(b2)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t m1, m2;
   logic prev1 = 1'b0;
   logic prev2 = 1'b0;

   logic [31:0] last1, last2;
   bit          last1_ok, last2_ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor for the clearing instance
   always @(negedge clk) begin
      if (b1.ready === 1'b1) begin
         check("clr ready back-to-back", 32'(prev1), 32'd0);
         if (q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL clr unexpected ready: got ready=1 expected no response");
         end else begin
            m1 = q1.pop_front();
            check("clr err", 32'(b1.err), 32'(m1.err));
            if (m1.chk) check("clr rdata", b1.rdata, m1.rdata);
         end
      end
      prev1 = b1.ready;
   end

   // Monitor for the preserving instance
   always @(negedge clk) begin
      if (b2.ready === 1'b1) begin
         check("keep ready back-to-back", 32'(prev2), 32'd0);
         if (q2.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL keep unexpected ready: got ready=1 expected no response");
         end else begin
            m2 = q2.pop_front();
            check("keep err", 32'(b2.err), 32'(m2.err));
            if (m2.chk) check("keep rdata", b2.rdata, m2.rdata);
         end
      end
      prev2 = b2.ready;
   end

   // One access: drive, queue expectations, wait for ready, check latency.
   // For reads e1/e2 are the expected data; writes expect rdata to hold,
   // except out-of-range writes where only err is checked.
   task automatic access(input string name, input bit wr, input bit rd,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] e1, input bit e_err,
                         input bit c2, input logic [31:0] e2);
      exp_t x1, x2;
      int   stalls;
      bit   got;
      if (wr) begin
         if (e_err) begin
            last1_ok = 1'b0;
            last2_ok = 1'b0;
         end
         x1.rdata = last1; x1.err = e_err; x1.chk = last1_ok;
         x2.rdata = last2; x2.err = e_err; x2.chk = last2_ok;
      end else begin
         x1.rdata = e1; x1.err = e_err; x1.chk = 1'b1;
         x2.rdata = e2; x2.err = e_err; x2.chk = c2;
         last1 = e1; last1_ok = 1'b1;
         last2 = e2; last2_ok = c2;
      end
      @(posedge clk);
      #1;
      b1.wr_en = wr; b1.rd_en = rd; b1.addr = a; b1.wdata = d; b1.wstrb = s;
      q1.push_back(x1);
      q2.push_back(x2);
      stalls = 0;
      got    = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (b1.ready === 1'b1) got = 1'b1;
         else if (b1.stall === 1'b1) stalls++;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: got no ready in 20 cycles expected ready", name);
      end else begin
         check({name, " stall cycles"}, 32'(stalls), 32'd3);
         check({name, " stall in RESP"}, 32'(b1.stall), 32'd0);
      end
      @(posedge clk);
      #1;
      b1.rd_en = 1'b0;
      b1.wr_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b1.rd_en = 1'b0; b1.wr_en = 1'b0; b1.addr = '0; b1.wdata = '0; b1.wstrb = '0;
      last1 = '0; last2 = '0; last1_ok = 1'b1; last2_ok = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset ready",      32'(b1.ready), 32'd0);
      check("reset err",        32'(b1.err),   32'd0);
      check("reset rdata clr",  b1.rdata,      32'd0);
      check("reset rdata keep", b2.rdata,      32'd0);
      check("reset stall",      32'(b1.stall), 32'd0);

      access("rd 1024",      0, 1, 32'd1024, 32'h0,        4'hF, 32'h0,        0, 0, 32'h0);
      access("wr 1028",      1, 0, 32'd1028, 32'hDEADBEEF, 4'hF, 32'h0,        0, 0, 32'h0);
      access("rd 1028 a",    0, 1, 32'd1028, 32'h0,        4'hF, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
      access("wr 1028 lane", 1, 0, 32'd1028, 32'h000000AA, 4'h1, 32'h0,        0, 0, 32'h0);
      access("rd 1028 b",    0, 1, 32'd1028, 32'h0,        4'hF, 32'hDEADBEAA, 0, 1, 32'hDEADBEAA);
      access("rd 1020 oor",  0, 1, 32'd1020, 32'h0,        4'hF, 32'h0,        1, 1, 32'h0);
      access("rd 1280 oor",  0, 1, 32'd1280, 32'h0,        4'hF, 32'h0,        1, 1, 32'h0);
      access("wr 1280 oor",  1, 0, 32'd1280, 32'h12345678, 4'hF, 32'h0,        1, 0, 32'h0);
      access("rd 1024 b",    0, 1, 32'd1024, 32'h0,        4'hF, 32'h0,        0, 0, 32'h0);
      access("rd 1028 c",    0, 1, 32'd1028, 32'h0,        4'hF, 32'hDEADBEAA, 0, 1, 32'hDEADBEAA);
      access("rdwr 1032",    1, 1, 32'd1032, 32'h5,        4'hF, 32'h0,        0, 0, 32'h0);
      access("rd 1032 a",    0, 1, 32'd1032, 32'h0,        4'hF, 32'h5,        0, 1, 32'h5);
      access("wr 1032 nostrb", 1, 0, 32'd1032, 32'hFFFFFFFF, 4'h0, 32'h0,      0, 0, 32'h0);
      access("rd 1032 b",    0, 1, 32'd1032, 32'h0,        4'hF, 32'h5,        0, 1, 32'h5);
      access("wr 1036",      1, 0, 32'd1036, 32'h11,       4'hF, 32'h0,        0, 0, 32'h0);

      // Write of 7 to 1036 aborted by reset while in WAIT
      @(posedge clk);
      #1;
      b1.wr_en = 1'b1; b1.addr = 32'd1036; b1.wdata = 32'h7; b1.wstrb = 4'hF;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      b1.wr_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort no ready", 32'(b1.ready), 32'd0);
      end
      check("abort rdata clr",  b1.rdata, 32'd0);
      check("abort rdata keep", b2.rdata, 32'd0);
      last1 = '0; last2 = '0; last1_ok = 1'b1; last2_ok = 1'b1;

      access("rd 1036 post", 0, 1, 32'd1036, 32'h0, 4'hF, 32'h0, 0, 1, 32'h11);
      access("rd 1032 post", 0, 1, 32'd1032, 32'h0, 4'hF, 32'h0, 0, 1, 32'h5);

      repeat (4) @(negedge clk);
      check("clr queue drained",  32'(q1.size()), 32'd0);
      check("keep queue drained", 32'(q2.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
